imem_responder: RTL and testbench

- Instruction-memory responder model serving the fetch unit's read requests: the slave end of the `mem_read` fetch interface.
- Holds a word-addressed instruction array, preloaded through a bench init port.
- Returns read data in order with a fixed latency and bounded outstanding requests.
- Drops in-flight responses on `flush` (branch redirect). Sits between the fetch unit and the testbench in the IFU verification environment.

---
 rtl/imem_responder.sv | 107 ++++++++++
 tb/tb_imem_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_responder
// Purpose  : Instruction-memory responder for the fetch read interface.
//            Fixed-latency, in-order, bounded-outstanding, flushable.
//            Optional macro IMEM_STALL_INJECT_EN adds LFSR-driven stalls.
// Revision : 1.0 - initial release
// ============================================================================
module imem_responder #(
    parameter int DEPTH_WORDS     = 256,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic [31:0] mem_addr,
    output logic        mem_ready,
    input  logic        flush,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        mem_error,
    input  logic        init_we,
    input  logic [31:0] init_addr,
    input  logic [31:0] init_data
);

    localparam int              c_AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int              c_CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0]     c_DEPTH = 32'(DEPTH_WORDS);
    localparam logic [c_CW-1:0] c_MAX   = c_CW'(MAX_OUTSTANDING);

    logic [31:0]     r_mem [DEPTH_WORDS];

    // Stage 0 is loaded at the accept edge; stage LATENCY drives the outputs.
    logic [LATENCY:0] r_vld;
    logic [LATENCY:0] r_err;
    logic [31:0]      r_dat [LATENCY+1];
    logic [c_CW-1:0]  r_cnt;

    logic            w_ready;
    logic            w_accept;
    logic            w_bad;
    logic            w_emit;
    logic [c_AW-1:0] w_word;

    assign w_bad    = (mem_addr[1:0] != 2'b00) || ({2'b00, mem_addr[31:2]} >= c_DEPTH);
    assign w_word   = mem_addr[c_AW+1:2];
    assign w_accept = mem_read && w_ready;
    assign w_emit   = r_vld[LATENCY-1] && !flush;

`ifdef IMEM_STALL_INJECT_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_ready = (r_cnt < c_MAX) && (r_lfsr[1:0] != 2'b00);
`else
    assign w_ready = (r_cnt < c_MAX);
`endif

    // Preload port; contents survive reset and are read old-value-first.
    always_ff @(posedge clk) begin
        if (init_we && (init_addr < c_DEPTH)) begin
            r_mem[init_addr[c_AW-1:0]] <= init_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_err <= '0;
            for (int j = 0; j <= LATENCY; j++) begin
                r_dat[j] <= '0;
            end
            r_cnt <= '0;
        end else begin
            r_vld[0] <= w_accept;
            r_err[0] <= w_accept && w_bad;
            r_dat[0] <= (w_accept && !w_bad) ? r_mem[w_word] : 32'h0;
            for (int j = 1; j <= LATENCY; j++) begin
                r_vld[j] <= r_vld[j-1] && !flush;
                r_err[j] <= r_err[j-1] && !flush;
                r_dat[j] <= flush ? 32'h0 : r_dat[j-1];
            end
            // The redirect target accepted during a flush is the only survivor.
            if (flush) begin
                r_cnt <= c_CW'(w_accept);
            end else begin
                r_cnt <= r_cnt + c_CW'(w_accept) - c_CW'(w_emit);
            end
        end
    end

    assign mem_ready  = w_ready;
    assign mem_rvalid = r_vld[LATENCY];
    assign mem_error  = r_err[LATENCY];
    assign mem_rdata  = r_dat[LATENCY];

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// Testbench for imem_responder: two instances (default, and LATENCY=4 /
// MAX_OUTSTANDING=2) checked against a cycle-scheduled response model.
module tb_imem_responder;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic        flush;
    logic        init_we;
    logic [31:0] init_addr;
    logic [31:0] init_data;

    logic        rdy0, rv0, re0;
    logic [31:0] rd0;
    logic        rdy1, rv1, re1;
    logic [31:0] rd1;

    int n_cmp = 0;
    int n_bad = 0;

    imem_responder dut0 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_ready(rdy0), .flush(flush), .mem_rvalid(rv0), .mem_rdata(rd0),
        .mem_error(re0), .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
    );

    imem_responder #(.DEPTH_WORDS(256), .LATENCY(4), .MAX_OUTSTANDING(2)) dut1 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_ready(rdy1), .flush(flush), .mem_rvalid(rv1), .mem_rdata(rd1),
        .mem_error(re1), .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic int max_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    // Model: every accepted request is scheduled to appear at cycle accept+LATENCY.
    logic [31:0] mmem [256];
    bit          sv   [2][8];
    bit          se   [2][8];
    logic [31:0] sd   [2][8];
    int          mcnt [2];
    bit          ev   [2];
    bit          ee   [2];
    logic [31:0] ed   [2];
    int          cyc = 0;
    bit          started = 0;

    initial begin
        for (int k = 0; k < 256; k++) mmem[k] = 32'h0;
    end

    always @(posedge clk) begin : p_model
        bit          acc, bad, emit;
        logic [31:0] rword;
        int          s;
        bad   = (mem_addr[1:0] != 2'b00) || (mem_addr[31:2] >= 30'd256);
        rword = bad ? 32'h0 : mmem[mem_addr[9:2]];
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int k = 0; k < 8; k++) sv[i][k] = 0;
                mcnt[i] = 0; ev[i] = 0; ee[i] = 0; ed[i] = 32'h0;
            end else begin
                acc   = mem_read && (mcnt[i] < max_of(i));
                s     = cyc % 8;
                emit  = sv[i][s] && !flush;
                ev[i] = emit;
                ee[i] = emit ? se[i][s] : 1'b0;
                ed[i] = emit ? sd[i][s] : 32'h0;
                sv[i][s] = 0;
                if (flush) begin
                    for (int k = 0; k < 8; k++) sv[i][k] = 0;
                    mcnt[i] = 0;
                end else if (emit) begin
                    mcnt[i] = mcnt[i] - 1;
                end
                if (acc) begin
                    s = (cyc + lat_of(i)) % 8;
                    sv[i][s] = 1; se[i][s] = bad; sd[i][s] = rword;
                    mcnt[i] = mcnt[i] + 1;
                end
            end
        end
        if (init_we && (init_addr < 32'd256)) mmem[init_addr[7:0]] = init_data;
        if (rst) started = 1;
        cyc++;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                logic        av, ae, ar, xr;
                logic [31:0] ad;
                av = (i == 0) ? rv0  : rv1;
                ae = (i == 0) ? re0  : re1;
                ad = (i == 0) ? rd0  : rd1;
                ar = (i == 0) ? rdy0 : rdy1;
                xr = (mcnt[i] < max_of(i));
                n_cmp++;
                if ({av, ae, ad, ar} !== {ev[i], ee[i], ed[i], xr}) begin
                    n_bad++;
                    $display("FAIL model dut%0d cycle %0d: got v=%b e=%b d=%h rdy=%b, want v=%b e=%b d=%h rdy=%b",
                             i, cyc, av, ae, ad, ar, ev[i], ee[i], ed[i], xr);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] a, input logic f, input logic w,
                         input logic [31:0] ia, input logic [31:0] id, input logic rs);
        @(negedge clk);
        mem_read = r; mem_addr = a; flush = f;
        init_we = w; init_addr = ia; init_data = id; rst = rs;
    endtask

    task automatic req(input logic r, input logic [31:0] a);
        drive(r, a, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input string nm, input logic [31:0] d, input logic e);
        at_edge();
        chk({nm, " valid"}, {31'b0, rv0}, 32'h1);
        chk({nm, " data"}, rd0, d);
        chk({nm, " error"}, {31'b0, re0}, {31'b0, e});
    endtask

    task automatic expect_none(input string nm);
        at_edge();
        chk({nm, " idle"}, {31'b0, rv0}, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) req(1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] v, a;
        int          sel;
        rst = 1'b1; mem_read = 1'b0; mem_addr = 32'h0; flush = 1'b0;
        init_we = 1'b0; init_addr = 32'h0; init_data = 32'h0;

        drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 1);
        at_edge();
        chk("reset ready", {31'b0, rdy0}, 32'h1);
        chk("reset rvalid", {31'b0, rv0}, 32'h0);
        chk("reset rdata", rd0, 32'h0);
        chk("reset error", {31'b0, re0}, 32'h0);

        for (int i = 0; i < 256; i++) begin
            case (i)
                0: v = 32'h0000_0013;
                1: v = 32'h0010_0093;
                2: v = 32'h0020_0113;
                3: v = 32'h0030_0193;
                4: v = 32'h0040_0213;
                5: v = 32'h0000_0000;
                default: v = $urandom;
            endcase
            drive(0, 32'h0, 0, 1, i, v, 0);
        end
        idle(2);

        // Back-to-back aligned reads.
        req(1, 32'h0);
        req(1, 32'h4);
        at_edge();
        chk("t1 no early resp", {31'b0, rv0}, 32'h0);
        req(1, 32'h8);
        expect_resp("t1 w0", 32'h0000_0013, 0);
        req(1, 32'hC);
        expect_resp("t1 w1", 32'h0010_0093, 0);
        req(0, 32'h0);
        expect_resp("t1 w2", 32'h0020_0113, 0);
        expect_resp("t1 w3", 32'h0030_0193, 0);
        expect_none("t1 after");
        idle(6);

        // Misaligned and out-of-range.
        req(1, 32'h6);
        req(1, 32'h400);
        req(0, 32'h0);
        expect_resp("t2 misaligned", 32'h0, 1);
        expect_resp("t2 range", 32'h0, 1);
        idle(6);

        // Flush with redirect accepted in the same cycle.
        req(1, 32'h0);
        req(1, 32'h4);
        drive(1, 32'h10, 1, 0, 32'h0, 32'h0, 0);
        expect_none("t4 flush edge");
        req(0, 32'h0);
        expect_none("t4 flushed 0x4");
        expect_resp("t4 target", 32'h0040_0213, 0);
        expect_none("t4 after");
        idle(6);

        // Read-before-write against a same-cycle preload.
        drive(1, 32'h14, 0, 1, 32'd5, 32'hDEAD_BEEF, 0);
        req(1, 32'h14);
        req(0, 32'h0);
        expect_resp("t5 old", 32'h0, 0);
        expect_resp("t5 new", 32'hDEAD_BEEF, 0);
        idle(8);

        // Backpressure on the LATENCY=4 / MAX_OUTSTANDING=2 instance.
        req(1, 32'h0);
        at_edge(); chk("t3 rdy e0", {31'b0, rdy1}, 32'h1);
        at_edge(); chk("t3 rdy e1", {31'b0, rdy1}, 32'h0);
        at_edge(); chk("t3 rdy e2", {31'b0, rdy1}, 32'h0);
        at_edge(); chk("t3 rdy e3", {31'b0, rdy1}, 32'h0);
        chk("t3 no resp e3", {31'b0, rv1}, 32'h0);
        at_edge();
        chk("t3 resp e4", {31'b0, rv1}, 32'h1);
        chk("t3 data e4", rd1, 32'h0000_0013);
        chk("t3 rdy e4", {31'b0, rdy1}, 32'h1);
        idle(10);

        // Reset with requests in flight.
        req(1, 32'h0);
        req(1, 32'h4);
        drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 1);
        at_edge();
        chk("t6 rvalid", {31'b0, rv0}, 32'h0);
        chk("t6 ready", {31'b0, rdy0}, 32'h1);
        chk("t6 rdata", rd0, 32'h0);
        chk("t6 error", {31'b0, re0}, 32'h0);
        req(0, 32'h0);
        expect_none("t6 lost");
        req(1, 32'h0);
        req(0, 32'h0);
        expect_none("t6 wait");
        expect_resp("t6 preserved", 32'h0000_0013, 0);
        idle(4);

        // Randomized traffic, model-checked every cycle.
        for (int k = 0; k < 4000; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)      a = 32'($urandom_range(0, 255)) << 2;
            else if (sel < 9) a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
            else              a = 32'($urandom_range(256, 4000)) << 2;
            drive($urandom_range(0, 99) < 70, a, $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 20, 32'($urandom_range(0, 299)), $urandom,
                  $urandom_range(0, 199) == 0);
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
